ex_muldiv: RTL and testbench

//  Multi-cycle multiply/divide unit and HI/LO register file in the EX stage, directly downstream of id_ex.

---
 rtl/ex_muldiv.sv | 205 ++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle multiply/divide unit with the architectural HI/LO
// registers, sitting in EX directly after id_ex.
// Optional feature macro: MULDIV_CANCEL_EN adds a flush port that abandons
// an in-flight operation and leaves HI/LO at their pre-op values.
module ex_muldiv #(
    parameter logic [7:0]  OP_MULT    = 8'h20,
    parameter logic [7:0]  OP_MULTU   = 8'h21,
    parameter logic [7:0]  OP_DIV     = 8'h22,
    parameter logic [7:0]  OP_DIVU    = 8'h23,
    parameter logic [7:0]  OP_MFHI    = 8'h24,
    parameter logic [7:0]  OP_MFLO    = 8'h25,
    parameter logic [7:0]  OP_MTHI    = 8'h26,
    parameter logic [7:0]  OP_MTLO    = 8'h27,
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  inst_name,
    input  logic [31:0] readData1,
    input  logic [31:0] readData2,
`ifdef MULDIV_CANCEL_EN
    input  logic        flush,
`endif
    output logic        stall,
    output logic        busy,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic [31:0] mf_result
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DIV_ITERS = 32;
    localparam int unsigned CNT_MAX = (MUL_CYCLES > DIV_ITERS) ? MUL_CYCLES : DIV_ITERS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                is_signed;
    logic                neg_q;
    logic                neg_r;
    logic [DATA_W-1:0]   quo;   // multiplicand during MUL, dividend/quotient during DIV
    logic [DATA_W-1:0]   dvs;   // multiplier during MUL, divisor during DIV
    logic [DATA_W-1:0]   rem;

    logic                cancel;
    logic                op_mul;
    logic                op_div;
    logic                op_signed;
    logic                op_mfmt;
    logic                start;
    logic [DATA_W-1:0]   abs_rs;
    logic [DATA_W-1:0]   abs_rt;

    logic [2*DATA_W-1:0] mul_a;
    logic [2*DATA_W-1:0] mul_b;
    logic [2*DATA_W-1:0] product;

    logic [DATA_W:0]     rem_sh;
    logic [DATA_W+1:0]   trial;
    logic [DATA_W-1:0]   rem_next;
    logic [DATA_W-1:0]   quo_next;
    logic [DATA_W-1:0]   quo_fixed;
    logic [DATA_W-1:0]   rem_fixed;

`ifdef MULDIV_CANCEL_EN
    assign cancel = flush;
`else
    assign cancel = 1'b0;
`endif

    // Opcode decode and accept condition; flush suppresses a same-cycle start
    always_comb begin
        op_mul    = (inst_name == OP_MULT) || (inst_name == OP_MULTU);
        op_div    = (inst_name == OP_DIV)  || (inst_name == OP_DIVU);
        op_signed = (inst_name == OP_MULT) || (inst_name == OP_DIV);
        op_mfmt   = (inst_name == OP_MFHI) || (inst_name == OP_MFLO) ||
                    (inst_name == OP_MTHI) || (inst_name == OP_MTLO);
        start     = in_valid && (state == IDLE) && (op_mul || op_div) && !cancel;
        abs_rs    = (op_signed && readData1[DATA_W-1]) ? (DATA_W'(0) - readData1) : readData1;
        abs_rt    = (op_signed && readData2[DATA_W-1]) ? (DATA_W'(0) - readData2) : readData2;
    end

    // Full 64-bit product from the latched operands, sign-extended for MULT
    always_comb begin
        mul_a   = is_signed ? {{DATA_W{quo[DATA_W-1]}}, quo} : {DATA_W'(0), quo};
        mul_b   = is_signed ? {{DATA_W{dvs[DATA_W-1]}}, dvs} : {DATA_W'(0), dvs};
        product = mul_a * mul_b;
    end

    // One restoring-divide step: shift in the next dividend bit, trial-subtract
    always_comb begin
        rem_sh = {rem, quo[DATA_W-1]};
        trial  = {1'b0, rem_sh} - {2'b00, dvs};
        if (trial[DATA_W+1]) begin
            rem_next = rem_sh[DATA_W-1:0];
            quo_next = {quo[DATA_W-2:0], 1'b0};
        end else begin
            rem_next = trial[DATA_W-1:0];
            quo_next = {quo[DATA_W-2:0], 1'b1};
        end
    end

    // Sign fix-up: quotient negative when signs differ, remainder follows dividend
    always_comb begin
        quo_fixed = neg_q ? (DATA_W'(0) - quo) : quo;
        rem_fixed = neg_r ? (DATA_W'(0) - rem) : rem;
    end

    // Control FSM, operand latches and HI/LO register file
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            is_signed <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quo       <= '0;
            dvs       <= '0;
            rem       <= '0;
            hi_out    <= '0;
            lo_out    <= '0;
        end else if (cancel) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        is_signed <= op_signed;
                        if (op_mul) begin
                            quo   <= readData1;
                            dvs   <= readData2;
                            cnt   <= CNT_W'(MUL_CYCLES);
                            state <= MUL;
                        end else if (readData2 == '0) begin
                            hi_out <= readData1;
                            lo_out <= '1;
                        end else begin
                            quo   <= abs_rs;
                            dvs   <= abs_rt;
                            rem   <= '0;
                            neg_q <= op_signed && (readData1[DATA_W-1] ^ readData2[DATA_W-1]);
                            neg_r <= op_signed && readData1[DATA_W-1];
                            cnt   <= CNT_W'(DIV_ITERS);
                            state <= DIV;
                        end
                    end else if (in_valid && (inst_name == OP_MTHI)) begin
                        hi_out <= readData1;
                    end else if (in_valid && (inst_name == OP_MTLO)) begin
                        lo_out <= readData1;
                    end
                end
                MUL: begin
                    if (cnt == CNT_W'(1)) begin
                        hi_out <= product[2*DATA_W-1:DATA_W];
                        lo_out <= product[DATA_W-1:0];
                        cnt    <= '0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DIV: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    lo_out <= quo_fixed;
                    hi_out <= rem_fixed;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Busy/stall: stall covers the accept cycle and every in-flight cycle
    always_comb begin
        busy  = (state != IDLE);
        stall = start || busy || (in_valid && busy && op_mfmt);
    end

    // Move-from-HI/LO read port
    always_comb begin
        mf_result = '0;
        if (inst_name == OP_MFHI) begin
            mf_result = hi_out;
        end else if (inst_name == OP_MFLO) begin
            mf_result = lo_out;
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed ops, expected HI/LO and mf_result queued by
// the driver and checked by an independent negedge monitor.
module tb_ex_muldiv;

    localparam logic [7:0] OP_MULT  = 8'h20;
    localparam logic [7:0] OP_MULTU = 8'h21;
    localparam logic [7:0] OP_DIV   = 8'h22;
    localparam logic [7:0] OP_DIVU  = 8'h23;
    localparam logic [7:0] OP_MFHI  = 8'h24;
    localparam logic [7:0] OP_MFLO  = 8'h25;
    localparam logic [7:0] OP_MTHI  = 8'h26;
    localparam logic [7:0] OP_MTLO  = 8'h27;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  inst_name;
    logic [31:0] readData1;
    logic [31:0] readData2;
`ifdef MULDIV_CANCEL_EN
    logic        flush;
`endif
    logic        stall;
    logic        busy;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [31:0] mf_result;

    always #5 clk = ~clk;

    ex_muldiv #(.MUL_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .inst_name (inst_name),
        .readData1 (readData1),
        .readData2 (readData2),
`ifdef MULDIV_CANCEL_EN
        .flush     (flush),
`endif
        .stall     (stall),
        .busy      (busy),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .mf_result (mf_result)
    );

    typedef struct {
        int          id;
        logic [31:0] hi;
        logic [31:0] lo;
        int          nbusy;
    } res_t;

    typedef struct {
        int          id;
        logic [31:0] val;
    } mf_t;

    res_t res_q[$];
    mf_t  mf_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   next_id  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: HI/LO checked when stall falls, mf_result when an MF op is not stalled
    logic prev_stall = 1'b0;
    int   busy_cnt   = 0;
    res_t mon_r;
    mf_t  mon_m;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            busy_cnt   = 0;
        end else begin
            if (busy) busy_cnt++;
            if (prev_stall && !stall) begin
                if (res_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got completion expected none");
                end else begin
                    mon_r = res_q.pop_front();
                    check($sformatf("res%0d_hi", mon_r.id), hi_out, mon_r.hi);
                    check($sformatf("res%0d_lo", mon_r.id), lo_out, mon_r.lo);
                    if (mon_r.nbusy >= 0)
                        check($sformatf("res%0d_busy_cycles", mon_r.id), 32'(busy_cnt), 32'(mon_r.nbusy));
                end
                busy_cnt = 0;
            end
            if (in_valid && !stall && (inst_name == OP_MFHI || inst_name == OP_MFLO)) begin
                if (mf_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_mf: got %h expected none", mf_result);
                end else begin
                    mon_m = mf_q.pop_front();
                    check($sformatf("mf%0d", mon_m.id), mf_result, mon_m.val);
                end
            end
            prev_stall = stall;
        end
    end

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!stall && !busy) done = 1'b1;
        end
        if (!done) check("idle_timeout", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Present a mul/div op for one accept cycle; stall must be high combinationally
    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        inst_name = op;
        readData1 = a;
        readData2 = b;
        in_valid  = 1'b1;
        #1;
        check("stall_accept", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        inst_name = 8'h00;
    endtask

    task automatic muldiv(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input int nb,
                          input bit wait_done);
        res_t r;
        r.id = next_id; r.hi = ehi; r.lo = elo; r.nbusy = nb;
        next_id++;
        res_q.push_back(r);
        issue(op, a, b);
        if (wait_done) wait_idle();
    endtask

    task automatic move_to(input logic [7:0] op, input logic [31:0] a);
        inst_name = op;
        readData1 = a;
        readData2 = 32'd0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        inst_name = 8'h00;
    endtask

    // MF op is held in EX until stall drops, as the frozen pipeline would do
    task automatic move_from(input logic [7:0] op, input logic [31:0] expv);
        mf_t m;
        bit done = 1'b0;
        m.id = next_id; m.val = expv;
        next_id++;
        mf_q.push_back(m);
        inst_name = op;
        in_valid  = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!stall) done = 1'b1;
        end
        if (!done) check("mf_timeout", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        inst_name = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        inst_name = 8'h00;
        readData1 = 32'd0;
        readData2 = 32'd0;
`ifdef MULDIV_CANCEL_EN
        flush     = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_busy",  32'(busy),  32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_hi",    hi_out,     32'd0);
        check("reset_lo",    lo_out,     32'd0);
        check("reset_mf",    mf_result,  32'd0);

        // Multiply and divide vectors (hand-computed)
        muldiv(OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 2,  1'b1);
        muldiv(OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33, 1'b1);
        muldiv(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b1);
        muldiv(OP_DIVU,  32'h00000055, 32'd0,        32'h00000055, 32'hFFFFFFFF, 0,  1'b1);
        muldiv(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1'b1);
        muldiv(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2,  1'b1);
        muldiv(OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 2,  1'b1);
        muldiv(OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 1'b1);

        // Move to/from HI/LO ordering
        move_to(OP_MTHI, 32'h00001234);
        move_from(OP_MFHI, 32'h00001234);
        move_to(OP_MTLO, 32'h0000ABCD);
        move_from(OP_MFLO, 32'h0000ABCD);
        move_from(OP_MFHI, 32'h00001234);

        // MFLO right behind MULTU must wait for the new product
        muldiv(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 2, 1'b0);
        move_from(OP_MFLO, 32'd42);

        // mf_result is zero for non-MF opcodes
        inst_name = OP_MULT;
        #1;
        check("mf_non_mf_op", mf_result, 32'd0);
        inst_name = 8'h00;
        @(posedge clk);
        #1;

        // Reset during the tenth divide iteration
        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        check("mid_div_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_busy",  32'(busy),  32'd0);
        check("rst_mid_stall", 32'(stall), 32'd0);
        check("rst_mid_hi",    hi_out,     32'd0);
        check("rst_mid_lo",    lo_out,     32'd0);

`ifdef MULDIV_CANCEL_EN
        // Flush during the tenth divide iteration keeps the old HI/LO
        move_to(OP_MTHI, 32'h00000011);
        move_to(OP_MTLO, 32'h00000022);
        muldiv(OP_DIVU, 32'd1000, 32'd3, 32'h00000011, 32'h00000022, -1, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_hi",   hi_out,    32'h00000011);
        check("flush_lo",   lo_out,    32'h00000022);
        wait_idle();
`endif

        repeat (3) @(posedge clk);
        #1;
        check("pending_results", 32'(res_q.size()), 32'd0);
        check("pending_mf",      32'(mf_q.size()),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
